// File: rtl/pad_turnaround_ctrl.sv
// Half-duplex direction controller for a group of bidirectional IO pads.
// Sequences pad I/OEN/REN with high-Z guard cycles on every direction change
// so local and remote drivers never overlap, and synchronizes pad C returns.
//
// Ports:
//   axis_clk, axis_rst_n  clock, asynchronous active-low reset
//   tx_valid/tx_data      local beat to drive; tx_ready (combinational) accepts it
//   rx_hold               remote side owns the bus; blocks a new TX start
//   rx_valid/rx_data      synchronized pad C sample, flagged valid after a flush
//   pad_i/pad_oen/pad_ren pad controls (oen all-ones = high-Z, ren 0 = pull on)
//   pad_c                 asynchronous pad return
//   dir_o                 1 while the pads are driven
//   state_o               IDLE=0, TURN_TX=1, DRIVE=2, TURN_RX=3
module pad_turnaround_ctrl #(
   parameter int unsigned WIDTH       = 12,
   parameter int unsigned TURN_CYC    = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             axis_clk,
   input  logic             axis_rst_n,
   input  logic             tx_valid,
   input  logic [WIDTH-1:0] tx_data,
   output logic             tx_ready,
   input  logic             rx_hold,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic [WIDTH-1:0] pad_i,
   output logic [WIDTH-1:0] pad_oen,
   output logic [WIDTH-1:0] pad_ren,
   input  logic [WIDTH-1:0] pad_c,
   output logic             dir_o,
   output logic [1:0]       state_o
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned FL_W  = 3;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN_CYC - 1);
   localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(SYNC_STAGES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TURN_TX = 2'd1,
      ST_DRIVE   = 2'd2,
      ST_TURN_RX = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FL_W-1:0]    flush_q, flush_d;
   logic [WIDTH-1:0]   pad_i_q, pad_i_d;
   logic [WIDTH-1:0]   pad_oen_q, pad_oen_d;
   logic [WIDTH-1:0]   pad_ren_q, pad_ren_d;
   logic               dir_q, dir_d;
   logic               rx_valid_q, rx_valid_d;
   logic [WIDTH-1:0]   sync_q [SYNC_STAGES];

   // Next-state, transfer and pad-control decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      flush_d  = flush_q;
      pad_i_d  = pad_i_q;
      tx_ready = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (flush_q != '0) flush_d = flush_q - FL_W'(1);
            // rx_hold wins over a simultaneous tx_valid
            if (tx_valid && !rx_hold) begin
               state_d = ST_TURN_TX;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_TURN_TX: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               tx_ready = 1'b1;
               if (tx_valid) begin
                  // first driven cycle already carries the accepted beat
                  state_d = ST_DRIVE;
                  pad_i_d = tx_data;
               end else begin
                  state_d = ST_IDLE;
                  flush_d = FL_LOAD;
               end
            end
         end
         ST_DRIVE: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               pad_i_d = tx_data;
            end else begin
               state_d = ST_TURN_RX;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_TURN_RX: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = ST_IDLE;
               flush_d = FL_LOAD;
            end
         end
         default: begin
            state_d = ST_IDLE;
            flush_d = FL_LOAD;
         end
      endcase

      pad_oen_d  = (state_d == ST_DRIVE) ? '0 : '1;
      pad_ren_d  = (state_d == ST_DRIVE) ? '1 : '0;
      dir_d      = (state_d == ST_DRIVE);
      // samples are only trusted once the chain has refilled in IDLE
      rx_valid_d = (state_d == ST_IDLE) && (flush_d == '0);
   end

   // Control and pad registers
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         flush_q    <= FL_LOAD;
         pad_i_q    <= '0;
         pad_oen_q  <= '1;
         pad_ren_q  <= '0;
         dir_q      <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         flush_q    <= flush_d;
         pad_i_q    <= pad_i_d;
         pad_oen_q  <= pad_oen_d;
         pad_ren_q  <= pad_ren_d;
         dir_q      <= dir_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   // pad_c synchronizer, runs in every state
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= pad_c;
         for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign state_o  = state_q;
   assign pad_i    = pad_i_q;
   assign pad_oen  = pad_oen_q;
   assign pad_ren  = pad_ren_q;
   assign dir_o    = dir_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_pad_turnaround_ctrl.sv
// Directed bench for pad_turnaround_ctrl with a per-cycle reference model.
module tb_pad_turnaround_ctrl;

   localparam int W  = 12;
   localparam int TC = 2;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tx_valid = 1'b0;
   logic [W-1:0]  tx_data = '0;
   logic          tx_ready;
   logic          rx_hold = 1'b0;
   logic          rx_valid;
   logic [W-1:0]  rx_data;
   logic [W-1:0]  pad_i, pad_oen, pad_ren;
   logic [W-1:0]  pad_c = '0;
   logic          dir_o;
   logic [1:0]    state_o;

   int n_chk  = 0;
   int n_pass = 0;

   pad_turnaround_ctrl #(.WIDTH(W), .TURN_CYC(TC), .SYNC_STAGES(SS)) dut (
      .axis_clk(clk), .axis_rst_n(rst_n),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_hold(rx_hold), .rx_valid(rx_valid), .rx_data(rx_data),
      .pad_i(pad_i), .pad_oen(pad_oen), .pad_ren(pad_ren), .pad_c(pad_c),
      .dir_o(dir_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: direction phase, cycles left in a turn, IDLE age, last beat
   int           m_phase = 0;   // 0 idle, 1 turning to tx, 2 driving, 3 turning to rx
   int           m_left  = 0;   // high-Z cycles still owed, including the current one
   int           m_age   = 0;   // edges seen since entering IDLE
   logic [W-1:0] m_pad   = '0;
   logic [W-1:0] m_hist [SS];

   initial for (int k = 0; k < SS; k++) m_hist[k] = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_left = 0; m_age = 0; m_pad = '0;
         for (int k = 0; k < SS; k++) m_hist[k] = '0;
      end else begin
         for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = pad_c;
         case (m_phase)
            0: begin
               m_age++;
               if (tx_valid && !rx_hold) begin m_phase = 1; m_left = TC; end
            end
            1: begin
               if (m_left > 1) m_left--;
               else if (tx_valid) begin m_phase = 2; m_pad = tx_data; end
               else begin m_phase = 0; m_age = 0; end
            end
            2: begin
               if (tx_valid) m_pad = tx_data;
               else begin m_phase = 3; m_left = TC; end
            end
            default: begin
               if (m_left > 1) m_left--;
               else begin m_phase = 0; m_age = 0; end
            end
         endcase
      end
   end

   // Per-cycle comparison against the model, plus the turnaround guard invariant
   int hz_run = 0;
   always @(negedge clk) begin
      bit drv, rdy;
      drv = (m_phase == 2);
      rdy = (m_phase == 2) || (m_phase == 1 && m_left == 1);
      chk("state_o",  int'(state_o),  m_phase);
      chk("pad_oen",  int'(pad_oen),  drv ? 0 : 'hFFF);
      chk("pad_ren",  int'(pad_ren),  drv ? 'hFFF : 0);
      chk("dir_o",    int'(dir_o),    int'(drv));
      chk("pad_i",    int'(pad_i),    int'(m_pad));
      chk("tx_ready", int'(tx_ready), int'(rdy));
      chk("rx_valid", int'(rx_valid), int'(m_phase == 0 && m_age >= SS));
      chk("rx_data",  int'(rx_data),  int'(m_hist[SS-1]));
      if (pad_oen == '1) hz_run++;
      else begin
         if (hz_run > 0) chk("oen_guard", int'(hz_run >= TC), 1);
         hz_run = 0;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send_beat(input logic [W-1:0] d, output int waited);
      tx_valid = 1'b1; tx_data = d; waited = 0;
      while (!tx_ready && waited < 50) begin step(); waited++; end
      chk("ready_seen", int'(tx_ready), 1);
      step();
   endtask

   initial begin
      int w;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state",  int'(state_o), 0);
      chk("rst_oen",    int'(pad_oen), 'hFFF);
      chk("rst_ren",    int'(pad_ren), 0);
      chk("rst_pad_i",  int'(pad_i), 0);
      chk("rst_rxv",    int'(rx_valid), 0);
      chk("rst_rxdata", int'(rx_data), 0);
      chk("rst_ready",  int'(tx_ready), 0);
      pad_c = 12'h123;
      rst_n = 1'b1;
      repeat (4) step();
      chk("idle_rxv", int'(rx_valid), 1);
      chk("idle_rxdata", int'(rx_data), 'h123);

      // TX burst
      pad_c = 12'h7E1;
      send_beat(12'h0A5, w);
      chk("turn_tx_len", w, 2);
      chk("b0_oen", int'(pad_oen), 0);
      chk("b0_pad", int'(pad_i), 'h0A5);
      chk("b0_state", int'(state_o), 2);
      send_beat(12'h15A, w);
      chk("b1_wait", w, 0);
      chk("b1_pad", int'(pad_i), 'h15A);
      send_beat(12'h3C3, w);
      chk("b2_pad", int'(pad_i), 'h3C3);
      tx_valid = 1'b0;
      step(); chk("rx1_state", int'(state_o), 3); chk("rx1_oen", int'(pad_oen), 'hFFF);
      chk("rx1_pad", int'(pad_i), 'h3C3);
      step(); chk("rx2_state", int'(state_o), 3);
      step(); chk("idle0_state", int'(state_o), 0); chk("idle0_rxv", int'(rx_valid), 0);
      step(); chk("idle1_rxv", int'(rx_valid), 0);
      step(); chk("idle2_rxv", int'(rx_valid), 1); chk("idle2_rxdata", int'(rx_data), 'h7E1);

      // hold priority
      rx_hold = 1'b1; tx_valid = 1'b1; tx_data = 12'h555;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_state", int'(state_o), 0);
         chk("hold_oen", int'(pad_oen), 'hFFF);
         chk("hold_ready", int'(tx_ready), 0);
      end
      rx_hold = 1'b0;
      step(); chk("unhold_state", int'(state_o), 1);

      // abort during turn
      tx_valid = 1'b0; tx_data = 12'hABC;
      step(); chk("abort_t1", int'(state_o), 1);
      step(); chk("abort_state", int'(state_o), 0);
      chk("abort_pad", int'(pad_i), 'h3C3);
      chk("abort_oen", int'(pad_oen), 'hFFF);

      // back-to-back reversal through IDLE
      repeat (3) step();
      send_beat(12'h111, w);
      chk("bb_pad0", int'(pad_i), 'h111);
      tx_valid = 1'b0;
      step(); chk("bb_rx1", int'(state_o), 3);
      tx_valid = 1'b1; tx_data = 12'h222;
      step(); chk("bb_rx2", int'(state_o), 3);
      step(); chk("bb_idle", int'(state_o), 0);
      step(); chk("bb_tx1", int'(state_o), 1); chk("bb_tx1_oen", int'(pad_oen), 'hFFF);
      step(); chk("bb_tx2", int'(state_o), 1); chk("bb_tx2_rdy", int'(tx_ready), 1);
      step(); chk("bb_drive", int'(state_o), 2); chk("bb_pad1", int'(pad_i), 'h222);
      tx_valid = 1'b0;
      repeat (6) step();

      // reset mid-DRIVE
      send_beat(12'h333, w);
      chk("pre_rst_state", int'(state_o), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_oen", int'(pad_oen), 'hFFF);
      chk("mrst_pad", int'(pad_i), 0);
      chk("mrst_state", int'(state_o), 0);
      chk("mrst_rxv", int'(rx_valid), 0);
      tx_valid = 1'b0;
      step(); step();
      rst_n = 1'b1;
      repeat (5) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pad_turnaround_ctrl.md
Name: pad_turnaround_ctrl

Overview:
- Half-duplex direction controller for a group of WIDTH bidirectional T18 IO pads.
- Shares the pads between local transmit beats and remote-driven receive. It sequences each pad's I, OEN and REN with guard turnaround cycles so that both sides never drive the pad at once.
- Synchronizes the pad C returns into the clock domain and presents them as received samples.
- Sits between the FSIC IO serdes logic and the pad ring instances.

Parameters:
WIDTH, 12, number of pads in the group.
TURN_CYC, 2, guard cycles with all pads high-Z on each direction change; legal range 1..15.
SYNC_STAGES, 2, flop depth of the pad_c synchronizer; legal range 2..4.

Ports:
axis_clk  input  1  clock.
axis_rst_n  input  1  asynchronous active-low reset.
tx_valid  input  1  local side has a beat to drive.
tx_data  input  WIDTH  beat value.
tx_ready  output  1  beat accepted when tx_valid&tx_ready at the rising edge.
rx_hold  input  1  remote side owns the bus; blocks TX start.
rx_valid  output  1  rx_data is a valid synchronized sample.
rx_data  output  WIDTH  synchronized pad_c.
pad_i  output  WIDTH  to pad I.
pad_oen  output  WIDTH  to pad OEN; all-ones means high-Z.
pad_ren  output  WIDTH  to pad REN; 0 enables the pull.
pad_c  input  WIDTH  from pad C; asynchronous.
dir_o  output  1  1 while pads are driven.
state_o  output  2  encoding: IDLE=0, TURN_TX=1, DRIVE=2, TURN_RX=3.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-DRIVE):
  - state=IDLE; pad_oen=all-ones; pad_ren=all-zeros; pad_i=0.
  - tx_ready=0; rx_valid=0; rx_data=0; dir_o=0.
  - Synchronizer flops=0; turn counter cnt=0; flush counter=SYNC_STAGES.
- All pad_* outputs, dir_o, state_o, rx_data and rx_valid are registered. tx_ready is combinational from state/cnt.
- pad_oen is all-zeros only in DRIVE, all-ones otherwise. pad_ren is all-ones in DRIVE, all-zeros otherwise. dir_o = (state==DRIVE).
- cnt is 4 bits.
- IDLE:
  - If tx_valid && !rx_hold, go to TURN_TX with cnt=TURN_CYC-1.
  - rx_hold=1 blocks TX indefinitely.
- TURN_TX:
  - Decrement cnt each cycle while cnt>0.
  - tx_ready=1 only when cnt==0.
  - At the edge with cnt==0:
    - If tx_valid: transfer, pad_i<=tx_data, go to DRIVE. The first driven cycle therefore already carries the new data.
    - Else: return to IDLE. The pads were never driven.
  - Result: exactly TURN_CYC high-Z cycles before the drive starts.
- DRIVE:
  - tx_ready=1.
  - Each edge with tx_valid transfers, updates pad_i and stays in DRIVE, giving one beat per cycle.
  - First edge with tx_valid=0: go to TURN_RX with cnt=TURN_CYC-1. pad_i holds its last value.
  - Every beat is held on the pad for at least one full cycle.
  - rx_hold is ignored in DRIVE; local ownership is not preempted.
- TURN_RX:
  - tx_ready=0.
  - Count down TURN_CYC cycles, then go to IDLE.
  - A tx_valid arriving during TURN_RX is serviced only via IDLE→TURN_TX. Direct reversal is not allowed.
- Synchronizer:
  - pad_c passes through SYNC_STAGES flops to rx_data every cycle in all states.
  - On each entry to IDLE the flush counter loads SYNC_STAGES.
  - The flush counter decrements each IDLE cycle.
  - rx_valid=1 only while state==IDLE and the flush counter==0, so samples taken while the bus was being driven or turning are never flagged valid.
- Leaving IDLE clears rx_valid on the same edge.
- Simultaneous tx_valid and rx_hold in IDLE: rx_hold wins; stay in IDLE.
- Changes to tx_data without a transfer never alter pad_i.

Test Plan:
- Reset: assert axis_rst_n=0 mid-DRIVE → pad_oen=12'hFFF and pad_i=0 in the same cycle, state_o=0, rx_valid=0.
- TX burst (TURN_CYC=2): tx_valid=1 with values 0x0A5, 0x15A, 0x3C3, then 0 → 2 cycles of pad_oen=FFF, then 3 DRIVE cycles with pad_i=0x0A5/0x15A/0x3C3 and pad_oen=000, then 2 TURN_RX cycles at FFF, then IDLE.
- RX flush: return to IDLE with pad_c=0x7E1 → rx_valid rises exactly SYNC_STAGES=2 cycles after entering IDLE, with rx_data=0x7E1. rx_valid=0 throughout DRIVE and both TURN states.
- Hold priority: rx_hold=1 and tx_valid=1 for 10 cycles → state_o stays 0, pad_oen=FFF, tx_ready=0. Drop rx_hold → TURN_TX on the next edge.
- Abort in turn: tx_valid drops during TURN_TX → return to IDLE with pad_oen never low and pad_i unchanged.
- Back-to-back: tx_valid reasserted during TURN_RX → full TURN_RX, then IDLE for 1 cycle, then TURN_TX for 2 cycles. pad_oen is never low within TURN_CYC cycles of a previous release.
